// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the multi-cycle ALU:
//   - 4-bit opcode constants presented on alu_mc.ctl
//   - FSM state encoding used by alu_mc
//   - operation select for the iterative multiplier/divider
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    typedef enum logic {
        MD_MUL = 1'b0,
        MD_DIV = 1'b1
    } md_op_t;

endpackage

// File: rtl/alu_muldiv.sv
// ----------------------------------------------------------------------------
// alu_muldiv
// Iterative unsigned multiplier (shift-add) / divider (restoring), one bit
// per clock, WIDTH iterations per operation.
// Ports:
//   clk, rst      clock, synchronous active-high reset (aborts any operation)
//   start         load operands and begin (ignored while busy is not checked;
//                 the controlling FSM only asserts it when idle)
//   op            MD_MUL or MD_DIV
//   a, b          operands (multiplicand/multiplier or dividend/divisor)
//   done          high during the cycle whose clock edge completes the last
//                 iteration; lo/hi then show the final values
//   lo, hi        value after the current iteration: product low/high, or
//                 quotient/remainder
// ----------------------------------------------------------------------------
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             busy_reg;
    md_op_t           op_reg;
    logic [WIDTH-1:0] opnd_reg;   // multiplicand or divisor
    logic [WIDTH-1:0] lo_reg;     // multiplier bits / dividend-quotient
    logic [WIDTH-1:0] hi_reg;     // partial product / partial remainder
    logic [CW-1:0]    cnt_reg;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_lo_next;
    logic [WIDTH-1:0] mul_hi_next;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_fit;
    logic [WIDTH-1:0] div_lo_next;
    logic [WIDTH-1:0] div_hi_next;
    logic             last;

    always_comb begin
        // Shift-add: add multiplicand when the current multiplier LSB is set,
        // then shift the {carry, hi, lo} pair right by one.
        mul_sum     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
        mul_hi_next = mul_sum[WIDTH:1];
        mul_lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};

        // Restoring division: bring the next dividend bit into the remainder,
        // trial-subtract, keep the difference only when it did not borrow.
        // With a zero divisor every trial fits, giving all-ones quotient and
        // the dividend shifted wholly into the remainder.
        div_shift   = {hi_reg, lo_reg[WIDTH-1]};
        div_diff    = div_shift - {1'b0, opnd_reg};
        div_fit     = ~div_diff[WIDTH];
        div_hi_next = div_fit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_lo_next = {lo_reg[WIDTH-2:0], div_fit};
    end

    assign last = (cnt_reg == CW'(WIDTH - 1));
    assign done = busy_reg && last;
    assign lo   = (op_reg == MD_DIV) ? div_lo_next : mul_lo_next;
    assign hi   = (op_reg == MD_DIV) ? div_hi_next : mul_hi_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg <= 1'b0;
            op_reg   <= MD_MUL;
            opnd_reg <= '0;
            lo_reg   <= '0;
            hi_reg   <= '0;
            cnt_reg  <= '0;
        end else if (start) begin
            busy_reg <= 1'b1;
            op_reg   <= op;
            opnd_reg <= (op == MD_DIV) ? b : a;
            lo_reg   <= (op == MD_DIV) ? a : b;
            hi_reg   <= '0;
            cnt_reg  <= '0;
        end else if (busy_reg) begin
            lo_reg <= lo;
            hi_reg <= hi;
            if (last) begin
                busy_reg <= 1'b0;
                cnt_reg  <= '0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// ----------------------------------------------------------------------------
// alu_mc
// Multi-cycle ALU. Logic/arithmetic ops complete one cycle after acceptance;
// MULTU/DIVU run WIDTH cycles in alu_muldiv under an IDLE/MUL/DIV FSM.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready request handshake (in_ready only in IDLE)
//   ctl, a, b         opcode and operands, captured at acceptance
//   out_valid         one-cycle completion pulse
//   result, hi        result/low product/quotient, high product/remainder
//   zero, ovf, err    SUB zero flag, ADD/SUB signed overflow, error flag
// ----------------------------------------------------------------------------
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             ovf,
    output logic             err
);

    state_t           state_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] hi_reg;
    logic             zero_reg;
    logic             ovf_reg;
    logic             err_reg;
    logic             dbz_reg;     // divisor was zero at DIVU acceptance

    logic             accept;
    logic             md_start;
    md_op_t           md_op;
    logic             md_done;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             alu_ovf;
    logic             alu_err;

    assign in_ready = (state_reg == ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign md_op    = (ctl == OP_DIVU) ? MD_DIV : MD_MUL;
    assign md_start = accept && ((ctl == OP_MULTU) || (ctl == OP_DIVU));

    always_comb begin
        sum     = a + b;
        diff    = a - b;
        add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

        alu_result = '0;
        alu_zero   = 1'b0;
        alu_ovf    = 1'b0;
        alu_err    = 1'b0;
        case (ctl)
            OP_AND: alu_result = a & b;
            OP_OR:  alu_result = a | b;
            OP_NOR: alu_result = ~(a | b);
            OP_ADD: begin
                alu_result = sum;
                alu_ovf    = add_ovf;
            end
            OP_SUB: begin
                alu_result = diff;
                alu_zero   = (diff == '0);
                alu_ovf    = sub_ovf;
            end
            // Sign of the difference is wrong exactly when it overflowed.
            OP_SLT: alu_result = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
            default: alu_err = 1'b1;
        endcase
    end

    alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .start (md_start),
        .op    (md_op),
        .a     (a),
        .b     (b),
        .done  (md_done),
        .lo    (md_lo),
        .hi    (md_hi)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            hi_reg        <= '0;
            zero_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            err_reg       <= 1'b0;
            dbz_reg       <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (ctl == OP_MULTU) begin
                            state_reg <= ST_MUL;
                        end else if (ctl == OP_DIVU) begin
                            state_reg <= ST_DIV;
                            dbz_reg   <= (b == '0);
                        end else begin
                            out_valid_reg <= 1'b1;
                            result_reg    <= alu_result;
                            hi_reg        <= '0;
                            zero_reg      <= alu_zero;
                            ovf_reg       <= alu_ovf;
                            err_reg       <= alu_err;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (md_done) begin
                        state_reg     <= ST_IDLE;
                        out_valid_reg <= 1'b1;
                        result_reg    <= md_lo;
                        hi_reg        <= md_hi;
                        zero_reg      <= 1'b0;
                        ovf_reg       <= 1'b0;
                        err_reg       <= (state_reg == ST_DIV) && dbz_reg;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign hi        = hi_reg;
    assign zero      = zero_reg;
    assign ovf       = ovf_reg;
    assign err       = err_reg;

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal 8..64).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operation request.
REQ-005 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-006 SHALL have port ctl  input  4  opcode: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, MULTU 1000, DIVU 1001.
REQ-007 SHALL have ports a, b  input  WIDTH  operands.
REQ-008 SHALL have port out_valid  output  1  one-cycle pulse, result fields valid.
REQ-009 SHALL have port result  output  WIDTH  logic result, sum, low product, or quotient.
REQ-010 SHALL have port hi  output  WIDTH  upper product (MULTU) or remainder (DIVU); 0 for other ops.
REQ-011 SHALL have port zero  output  1  result==0, for SUB only; 0 for other ops.
REQ-012 SHALL have port ovf  output  1  signed overflow, for ADD/SUB only.
REQ-013 SHALL have port err  output  1  undefined opcode or divide-by-zero.

Function
REQ-014 SHALL accept a request on an edge where in_valid && in_ready; in_valid with in_ready low is ignored, not queued.
REQ-015 SHALL implement FSM states IDLE, MUL, DIV; in_ready = (state==IDLE).
REQ-016 SHALL, for single-cycle ops (AND/OR/ADD/SUB/SLT/NOR/undefined), register outputs and pulse out_valid on the edge after acceptance, staying in IDLE (back-to-back every cycle).
REQ-017 SHALL compute SLT as a correct signed compare (overflow-corrected), result 1 or 0.
REQ-018 SHALL, for an undefined opcode, return result=0, hi=0, err=1 with single-cycle timing.
REQ-019 SHALL run MULTU as unsigned shift-add, one bit per cycle: IDLE->MUL on acceptance, WIDTH iterations, MUL->IDLE on the last one.
REQ-020 SHALL run DIVU as unsigned restoring division, one quotient bit per cycle, IDLE->DIV->IDLE with the same timing as MULTU.
REQ-021 SHALL, for MULTU/DIVU accepted at edge E0, register outputs and out_valid at edge E0+WIDTH; in_ready low after E0 through E0+WIDTH, high in the out_valid cycle.
REQ-022 SHALL, for DIVU with b==0, complete with normal timing and give result=all ones, hi=a, err=1.
REQ-023 SHALL hold result/hi/zero/ovf/err stable between out_valid pulses; out_valid has no backpressure.
REQ-024 SHALL latch a, b and ctl at acceptance; input changes during MUL/DIV have no effect.
REQ-025 SHALL keep the iteration counter at ceil(log2(WIDTH+1)) bits with no wrap beyond WIDTH.

Reset
REQ-026 SHALL, while rst is high at an edge, force state=IDLE, counter=0, out_valid=0, result=0, hi=0, zero=0, ovf=0, err=0.
REQ-027 SHALL, when rst is high mid-MULTU/DIVU, abort with no out_valid; in_ready is high in the cycle after rst deasserts.
REQ-028 SHALL give rst priority over a simultaneous in_valid (request dropped).

Structure
REQ-029 SHALL place opcode constants and the FSM state encoding in shared package alu_pkg.
REQ-030 SHALL implement the iterative multiplier/divider as sub-module alu_muldiv (start, op, a, b -> done, lo, hi), with the FSM in alu_mc.

Verification (WIDTH=32)
REQ-031 SHALL test ADD 0x7FFFFFFF+0x00000001 -> result 0x80000000, ovf=1, out_valid one cycle after accept.
REQ-032 SHALL test SUB 5-5 -> result 0, zero=1; then SLT a=0xFFFFFFFF b=1 -> result 1, zero=0.
REQ-033 SHALL test MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi 0xFFFFFFFE, result 0x00000001, out_valid exactly 32 edges after accept, in_ready low for 32 cycles, in_valid pulses meanwhile ignored.
REQ-034 SHALL test DIVU 100/7 -> result 14, hi 2, err 0; then DIVU 9/0 -> result 0xFFFFFFFF, hi 9, err 1.
REQ-035 SHALL test rst pulsed at iteration 10 of MULTU -> no out_valid, outputs 0, in_ready 1; then ADD 2+3 -> result 5.
REQ-036 SHALL test AND, OR, NOR and opcode 1111 issued on consecutive cycles -> four consecutive out_valid pulses, last with result 0, err 1.
